draw_arbiter: RTL and testbench

Shares the single VGA pixel-write port between up to NREQ rectangle requesters: brick draw/erase, ball, paddle, and screen clear.
- Grants one requester at a time using round-robin priority.
- Latches the granted requester's rectangle and rasters it one pixel per clock.
- Pulses a per-requester done when the last pixel is written.
- Sits between the game FSMs and the VGA adapter's x/y/colour/writeEn inputs.

---
 rtl/draw_arbiter_pkg.sv | 25 ++
 rtl/draw_arbiter_if.sv | 37 +++
 rtl/draw_arbiter_rect_raster.sv | 59 +++++
 rtl/draw_arbiter.sv | 154 +++++++++++++++
 tb/tb_draw_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_arbiter_pkg.sv
// draw_arbiter_pkg: shared defaults and state encoding for the draw arbiter.
//   NREQ_DEF / COORD_W_DEF / SIZE_W_DEF / COLOR_W_DEF : default widths
//   ST_IDLE / ST_DRAW / ST_DONE                       : FSM state codes
//   rr_next()                                          : round-robin successor
package draw_arbiter_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int COORD_W_DEF = 10;
  localparam int SIZE_W_DEF  = 6;
  localparam int COLOR_W_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index that follows idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if ((idx + 32'd1) >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// draw_arbiter_if: requester-side and VGA-side signals of the draw arbiter.
//   req/rect_*      : per-requester level request and packed rectangle payload
//   grant/done/busy : arbitration status back to the requesters
//   plot_*          : pixel write port towards the VGA adapter
// Modports: master = requesters/VGA side, slave = the arbiter.
interface draw_arbiter_if #(
  parameter int NREQ    = draw_arbiter_pkg::NREQ_DEF,
  parameter int COORD_W = draw_arbiter_pkg::COORD_W_DEF,
  parameter int SIZE_W  = draw_arbiter_pkg::SIZE_W_DEF,
  parameter int COLOR_W = draw_arbiter_pkg::COLOR_W_DEF
);

  logic [NREQ-1:0]         req;
  logic [NREQ*COORD_W-1:0] rect_x;
  logic [NREQ*COORD_W-1:0] rect_y;
  logic [NREQ*SIZE_W-1:0]  rect_w;
  logic [NREQ*SIZE_W-1:0]  rect_h;
  logic [NREQ*COLOR_W-1:0] rect_color;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    busy;
  logic                    plot_en;
  logic [COORD_W-1:0]      plot_x;
  logic [COORD_W-1:0]      plot_y;
  logic [COLOR_W-1:0]      plot_color;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_color,
    input  grant, done, busy, plot_en, plot_x, plot_y, plot_color
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_color,
    output grant, done, busy, plot_en, plot_x, plot_y, plot_color
  );

endinterface

// File: rtl/draw_arbiter_rect_raster.sv
// rect_raster: column-major pixel walker for one rectangle.
//   clk, resetn : clock, synchronous active-low reset
//   start       : load counters to (0,0) and begin walking (size must be non-zero)
//   w, h        : rectangle size, held stable while active
//   qx, qy      : current pixel offset
//   active      : a pixel offset is valid this cycle
//   last        : current offset is the final pixel (w-1, h-1)
module rect_raster #(
  parameter int SIZE_W = draw_arbiter_pkg::SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  output logic [SIZE_W-1:0] qx,
  output logic [SIZE_W-1:0] qy,
  output logic              active,
  output logic              last
);

  logic [SIZE_W-1:0] qx_r;
  logic [SIZE_W-1:0] qy_r;
  logic              active_r;
  logic              col_end_s;

  assign col_end_s = (qy_r == (h - SIZE_W'(1)));
  assign last      = active_r && col_end_s && (qx_r == (w - SIZE_W'(1)));
  assign qx        = qx_r;
  assign qy        = qy_r;
  assign active    = active_r;

  // Walk down each column, then step to the next column.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      qx_r     <= '0;
      qy_r     <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      qx_r     <= '0;
      qy_r     <= '0;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (last) begin
        qx_r     <= '0;
        qy_r     <= '0;
        active_r <= 1'b0;
      end else if (col_end_s) begin
        qy_r <= '0;
        qx_r <= qx_r + SIZE_W'(1);
      end else begin
        qy_r <= qy_r + SIZE_W'(1);
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the VGA pixel-write port between NREQ rectangle requesters.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : req/rect_* in; grant/done/busy and plot_* out
// Round-robin pick in IDLE, latch the winner's rectangle, raster it one pixel
// per clock in DRAW, pulse done for one cycle in DONE.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input logic           clk,
  input logic           resetn,
  draw_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]         state_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   gidx_r;
  logic [NREQ-1:0]    grant_r;
  logic [NREQ-1:0]    done_r;
  logic [COORD_W-1:0] x0_r;
  logic [COORD_W-1:0] y0_r;
  logic [SIZE_W-1:0]  w_r;
  logic [SIZE_W-1:0]  h_r;
  logic [COLOR_W-1:0] color_r;

  logic               pick_found_s;
  logic [PTR_W-1:0]   pick_idx_s;
  int unsigned        cand_s;
  logic [NREQ-1:0]    pick_onehot_s;
  logic [SIZE_W-1:0]  pick_w_s;
  logic [SIZE_W-1:0]  pick_h_s;
  logic               pick_zero_s;
  logic               start_s;
  logic [SIZE_W-1:0]  qx_s;
  logic [SIZE_W-1:0]  qy_s;
  logic               active_s;
  logic               last_s;
  logic               drawing_s;

  // Round-robin scan: first set req bit starting at ptr, wrapping.
  always_comb begin
    pick_found_s  = 1'b0;
    pick_idx_s    = '0;
    cand_s        = 32'd0;
    pick_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = 32'(ptr_r) + 32'(i);
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && bus.req[cand_s[PTR_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    pick_onehot_s[pick_idx_s] = 1'b1;
  end

  assign pick_w_s    = bus.rect_w[pick_idx_s*SIZE_W +: SIZE_W];
  assign pick_h_s    = bus.rect_h[pick_idx_s*SIZE_W +: SIZE_W];
  assign pick_zero_s = (pick_w_s == '0) || (pick_h_s == '0);
  assign start_s     = (state_r == ST_IDLE) && pick_found_s && !pick_zero_s;

  rect_raster #(.SIZE_W(SIZE_W)) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_s),
    .w      (w_r),
    .h      (h_r),
    .qx     (qx_s),
    .qy     (qy_s),
    .active (active_s),
    .last   (last_s)
  );

  // Arbitration FSM with payload latch; ptr only advances once a grant completes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      gidx_r  <= '0;
      grant_r <= '0;
      done_r  <= '0;
      x0_r    <= '0;
      y0_r    <= '0;
      w_r     <= '0;
      h_r     <= '0;
      color_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            gidx_r  <= pick_idx_s;
            grant_r <= pick_onehot_s;
            x0_r    <= bus.rect_x[pick_idx_s*COORD_W +: COORD_W];
            y0_r    <= bus.rect_y[pick_idx_s*COORD_W +: COORD_W];
            w_r     <= pick_w_s;
            h_r     <= pick_h_s;
            color_r <= bus.rect_color[pick_idx_s*COLOR_W +: COLOR_W];
            if (pick_zero_s) begin
              // Nothing to plot: go straight to the done pulse.
              state_r <= ST_DONE;
              done_r  <= pick_onehot_s;
            end else begin
              state_r <= ST_DRAW;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAW: begin
          if (last_s) begin
            state_r <= ST_DONE;
            done_r  <= grant_r;
          end else begin
            state_r <= ST_DRAW;
          end
        end
        ST_DONE: begin
          done_r  <= '0;
          grant_r <= '0;
          ptr_r   <= PTR_W'(rr_next(32'(gidx_r), NREQ));
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= '0;
          grant_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Pixel port is a pure decode of registered state; zero outside DRAW.
  assign drawing_s      = (state_r == ST_DRAW) && active_s;
  assign bus.plot_en    = drawing_s;
  assign bus.plot_x     = drawing_s ? (x0_r + COORD_W'(qx_s)) : '0;
  assign bus.plot_y     = drawing_s ? (y0_r + COORD_W'(qy_s)) : '0;
  assign bus.plot_color = drawing_s ? color_r : '0;
  assign bus.grant      = grant_r;
  assign bus.done       = done_r;
  assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: self-checking bench for draw_arbiter.
// A transaction-level model expands every grant into its expected cycle list
// (pixels, done, idle) and compares all outputs every cycle; table vectors and
// hand sequences add targeted checks on top.
module tb_draw_arbiter;
  import draw_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 10;
  localparam int SW   = 6;
  localparam int KW   = 3;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            en;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic [KW-1:0]   c;
  } obs_t;

  typedef struct {
    int idx; int x; int y; int w; int h; int c;
    int n_pix; int fx; int fy; int lx; int ly;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_arbiter_if bus ();
  draw_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  logic [NREQ-1:0] rq;
  int rx[NREQ], ry[NREQ], rw[NREQ], rh[NREQ], rc[NREQ];
  bit auto_clear = 1'b1;

  obs_t exp_q[$];
  obs_t cur_exp;
  int   mptr;
  int   pix_x[$], pix_y[$], done_log[$];
  vec_t tbl[5];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic apply();
    bus.req = rq;
    for (int i = 0; i < NREQ; i++) begin
      bus.rect_x[i*CW +: CW]     = CW'(rx[i]);
      bus.rect_y[i*CW +: CW]     = CW'(ry[i]);
      bus.rect_w[i*SW +: SW]     = SW'(rw[i]);
      bus.rect_h[i*SW +: SW]     = SW'(rh[i]);
      bus.rect_color[i*KW +: KW] = KW'(rc[i]);
    end
  endtask

  // Model of one clock edge: the cycle after the edge is whatever the schedule says.
  task automatic model_edge();
    obs_t o;
    int g;
    if (!resetn) begin
      exp_q.delete();
      mptr = 0;
      cur_exp = '0;
    end else if (exp_q.size() != 0) begin
      cur_exp = exp_q.pop_front();
    end else if (rq != '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && rq[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
      for (int cx = 0; cx < rw[g]; cx++) begin
        for (int cy = 0; cy < rh[g]; cy++) begin
          o = '0;
          o.grant = NREQ'(1) << g;
          o.busy = 1'b1;
          o.en = 1'b1;
          o.x = CW'((rx[g] + cx) % 1024);
          o.y = CW'((ry[g] + cy) % 1024);
          o.c = KW'(rc[g]);
          exp_q.push_back(o);
        end
      end
      o = '0;
      o.grant = NREQ'(1) << g;
      o.done = NREQ'(1) << g;
      o.busy = 1'b1;
      exp_q.push_back(o);
      exp_q.push_back(obs_t'('0));
      mptr = (g + 1) % NREQ;
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = '0;
    end
  endtask

  task automatic step();
    obs_t act;
    apply();
    model_edge();
    @(posedge clk);
    #1;
    cyc_no++;
    act = {bus.grant, bus.done, bus.busy, bus.plot_en, bus.plot_x, bus.plot_y, bus.plot_color};
    checks++;
    if (act !== cur_exp) begin
      failures++;
      $display("FAIL cycle %0d: got grant=%b done=%b busy=%b en=%b x=%0d y=%0d c=%0d, want grant=%b done=%b busy=%b en=%b x=%0d y=%0d c=%0d",
               cyc_no, act.grant, act.done, act.busy, act.en, act.x, act.y, act.c,
               cur_exp.grant, cur_exp.done, cur_exp.busy, cur_exp.en, cur_exp.x, cur_exp.y, cur_exp.c);
    end
    if (bus.plot_en === 1'b1) begin
      pix_x.push_back(int'(bus.plot_x));
      pix_y.push_back(int'(bus.plot_y));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.done[i] === 1'b1) done_log.push_back(i);
      if (cur_exp.done[i] && auto_clear) rq[i] = 1'b0;
    end
  endtask

  task automatic run_until_quiet(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && rq == '0 && cur_exp == '0) && n < budget);
    if (!(exp_q.size() == 0 && rq == '0 && cur_exp == '0)) begin
      checks++;
      failures++;
      $display("FAIL timeout: still busy after %0d cycles, want quiet", n);
    end
  endtask

  task automatic clear_logs();
    pix_x.delete();
    pix_y.delete();
    done_log.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rq = '0;
    for (int i = 0; i < NREQ; i++) set_rect(i, 0, 0, 1, 1, 0);

    // Reset state: outputs all zero while resetn is low.
    resetn = 1'b0;
    step();
    step();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_grant", int'(bus.grant), 0);
    resetn = 1'b1;

    // Table-driven single-requester rectangles.
    tbl[0] = '{0, 100, 50, 3, 2, 5, 6, 100, 50, 102, 51};
    tbl[1] = '{1, 10, 10, 0, 4, 3, 0, 0, 0, 0, 0};
    tbl[2] = '{2, 1022, 7, 4, 1, 6, 4, 1022, 7, 1, 7};
    tbl[3] = '{3, 1023, 1023, 2, 2, 7, 4, 1023, 1023, 0, 0};
    tbl[4] = '{0, 5, 9, 1, 1, 1, 1, 5, 9, 5, 9};
    for (int t = 0; t < 5; t++) begin
      clear_logs();
      set_rect(tbl[t].idx, tbl[t].x, tbl[t].y, tbl[t].w, tbl[t].h, tbl[t].c);
      rq = NREQ'(1) << tbl[t].idx;
      run_until_quiet(200);
      chk($sformatf("tbl%0d_npix", t), pix_x.size(), tbl[t].n_pix);
      if (tbl[t].n_pix > 0 && pix_x.size() > 0) begin
        chk($sformatf("tbl%0d_first_x", t), pix_x[0], tbl[t].fx);
        chk($sformatf("tbl%0d_first_y", t), pix_y[0], tbl[t].fy);
        chk($sformatf("tbl%0d_last_x", t), pix_x[pix_x.size()-1], tbl[t].lx);
        chk($sformatf("tbl%0d_last_y", t), pix_y[pix_y.size()-1], tbl[t].ly);
      end
      chk($sformatf("tbl%0d_ndone", t), done_log.size(), 1);
      chk($sformatf("tbl%0d_done_idx", t), (done_log.size() > 0) ? done_log[0] : -1, tbl[t].idx);
    end

    // Simultaneous requests right after reset: 0 before 2.
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_rect(i, 20 * i, 30, 1, 1, i);
    rq = 4'b0101;
    run_until_quiet(100);
    chk("simul_ndone", done_log.size(), 2);
    chk("simul_first", (done_log.size() > 0) ? done_log[0] : -1, 0);
    chk("simul_second", (done_log.size() > 1) ? done_log[1] : -1, 2);

    // All four held after reset: order 0,1,2,3,0.
    do_reset();
    clear_logs();
    auto_clear = 1'b0;
    rq = 4'b1111;
    n = 0;
    while (done_log.size() < 5 && n < 100) begin
      step();
      n++;
    end
    rq = '0;
    auto_clear = 1'b1;
    run_until_quiet(50);
    chk("hold_ndone", done_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_order%0d", k), (done_log.size() > k) ? done_log[k] : -1, k % NREQ);
    end

    // Payload change and req drop mid-draw are ignored.
    clear_logs();
    set_rect(0, 200, 20, 2, 3, 6);
    rq = 4'b0001;
    step();
    step();
    step();
    rx[0] = 300;
    rw[0] = 5;
    rq[0] = 1'b0;
    run_until_quiet(100);
    chk("midchg_npix", pix_x.size(), 6);
    n = 0;
    foreach (pix_x[k]) if (pix_x[k] < 200 || pix_x[k] > 201) n++;
    chk("midchg_bad_x", n, 0);
    chk("midchg_ndone", done_log.size(), 1);

    // Reset on the third pixel: no done, pointer back to 0.
    clear_logs();
    set_rect(0, 40, 40, 4, 2, 2);
    set_rect(1, 60, 60, 1, 2, 3);
    set_rect(2, 80, 80, 2, 1, 4);
    rq = 4'b0001;
    step();
    step();
    step();
    chk("rst_mid_npix_before", pix_x.size(), 3);
    resetn = 1'b0;
    rq = 4'b0110;
    step();
    chk("rst_mid_plot_en", int'(bus.plot_en), 0);
    chk("rst_mid_grant", int'(bus.grant), 0);
    chk("rst_mid_ndone", done_log.size(), 0);
    resetn = 1'b1;
    run_until_quiet(100);
    chk("rst_after_ndone", done_log.size(), 2);
    chk("rst_after_first", (done_log.size() > 0) ? done_log[0] : -1, 1);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq[i] && $urandom_range(7, 0) == 0) begin
          set_rect(i, $urandom_range(1023, 0), $urandom_range(1023, 0),
                   $urandom_range(5, 0), $urandom_range(5, 0), $urandom_range(7, 0));
          rq[i] = 1'b1;
        end else if (cur_exp.grant[i] && $urandom_range(3, 0) == 0) begin
          rx[i] = $urandom_range(1023, 0);
          rc[i] = $urandom_range(7, 0);
        end
      end
      step();
    end
    run_until_quiet(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
